// File: rtl/reg_probe_display.sv
// reg_probe_display: reads one datapath register over a req/ack debug port and shows it on active-low 7-seg digits
// Ports:
//   clk_i, reset_i      single clock, synchronous active-high reset
//   sw_idx_i            register index to view
//   sw_page_i           page select in manual mode
//   auto_scroll_i       1 = cycle pages automatically
//   rd_req_o, rd_idx_o  debug read request and its index (stable while rd_req_o=1)
//   rd_ack_i, rd_data_i read completion and data (same cycle)
//   hex_o               digit i on hex_o[7*i +: 7], active-low, bit0=a .. bit6=g
//   valid_o             displayed value belongs to the current sw_idx_i
//   err_o               last read timed out
module reg_probe_display #(
  parameter int DATA_W         = 32,
  parameter int IDX_W          = 5,
  parameter int NUM_DIGITS     = 2,
  parameter int SCROLL_CYCLES  = 25_000_000,
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PAGES  = DATA_W / (4 * NUM_DIGITS),
  localparam int PAGE_W = PAGES > 1 ? $clog2(PAGES) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [IDX_W-1:0]        sw_idx_i,
  input  logic [PAGE_W-1:0]       sw_page_i,
  input  logic                    auto_scroll_i,
  output logic                    rd_req_o,
  output logic [IDX_W-1:0]        rd_idx_o,
  input  logic                    rd_ack_i,
  input  logic [DATA_W-1:0]       rd_data_i,
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic                    valid_o,
  output logic                    err_o
);
  localparam int SCR_W = $clog2(SCROLL_CYCLES);
  localparam int REF_W = $clog2(REFRESH_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int WIN_W = 4 * NUM_DIGITS;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, REQ} state_e;
  state_e state_q, state_d;

  logic [IDX_W-1:0]        idx_q, idx_d, rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    rd_req_q, rd_req_d, valid_q, valid_d, err_q, err_d;
  logic                    first_q, first_d;
  logic                    shown_q, shown_d;
  logic [REF_W-1:0]        ref_q, ref_d;
  logic [TO_W-1:0]         wait_q, wait_d;
  logic [SCR_W-1:0]        scr_q, scr_d;
  logic [PAGE_W-1:0]       apage_q, apage_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    idx_chg, refresh, timeout, go, scr_wrap, page_ok;
  logic [PAGE_W-1:0]       page;
  logic [WIN_W-1:0]        win;

  // first_q forces a read right after reset even when sw_idx_i already equals idx_q
  assign idx_chg  = first_q || (sw_idx_i != idx_q);
  assign refresh  = ref_q == REF_W'(REFRESH_CYCLES - 1);
  assign timeout  = wait_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign go       = idx_chg || refresh;
  assign scr_wrap = scr_q == SCR_W'(SCROLL_CYCLES - 1);

  always_ff @(posedge clk_i)
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (go ? REQ : IDLE) : (rd_ack_i || timeout ? IDLE : REQ);

  always_comb begin
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    rd_req_d = rd_req_q;
    data_d   = data_q;
    valid_d  = valid_q;
    err_d    = err_q;
    first_d  = first_q;
    shown_d  = shown_q;
    ref_d    = ref_q;
    wait_d   = wait_q;
    if (state_q == IDLE) begin
      ref_d = go ? '0 : ref_q + 1'b1;
      if (go) begin
        rd_req_d = 1'b1;
        wait_d   = '0;
        first_d  = 1'b0;
        idx_d    = idx_chg ? sw_idx_i : idx_q;
        rd_idx_d = idx_chg ? sw_idx_i : idx_q;
        valid_d  = idx_chg ? 1'b0 : valid_q;
      end
    end else begin
      ref_d  = '0;
      wait_d = wait_q + 1'b1;
      if (rd_ack_i) begin
        data_d   = rd_data_i;
        rd_req_d = 1'b0;
        err_d    = 1'b0;
        shown_d  = 1'b1;
        // data read for an index the user has since left is kept out of valid
        valid_d  = sw_idx_i == idx_q;
      end else if (timeout) begin
        rd_req_d = 1'b0;
        err_d    = 1'b1;
        valid_d  = 1'b0;
        shown_d  = 1'b1;
      end
    end
  end

  always_comb begin
    scr_d   = !auto_scroll_i || scr_wrap ? '0 : scr_q + 1'b1;
    apage_d = !auto_scroll_i ? '0 :
              !scr_wrap ? apage_q :
              apage_q == PAGE_W'(PAGES - 1) ? '0 : apage_q + 1'b1;
  end

  always_comb begin
    page    = auto_scroll_i ? apage_q : sw_page_i;
    page_ok = auto_scroll_i || int'(sw_page_i) < PAGES;
    win     = WIN_W'(data_q >> (WIN_W * int'(page)));
    hex_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      hex_d[7*i +: 7] = !shown_q ? SEG_BLANK :
                        err_q    ? SEG_E :
                        !valid_q ? SEG_DASH :
                        !page_ok ? SEG_BLANK : FONT[win[4*i +: 4]];
  end

  always_ff @(posedge clk_i)
    if (reset_i) begin
      idx_q    <= '0;
      rd_idx_q <= '0;
      rd_req_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b1;
      shown_q  <= 1'b0;
      ref_q    <= '0;
      wait_q   <= '0;
      scr_q    <= '0;
      apage_q  <= '0;
      hex_q    <= '1;
    end else begin
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      rd_req_q <= rd_req_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      first_q  <= first_d;
      shown_q  <= shown_d;
      ref_q    <= ref_d;
      wait_q   <= wait_d;
      scr_q    <= scr_d;
      apage_q  <= apage_d;
      hex_q    <= hex_d;
    end

  assign rd_req_o = rd_req_q;
  assign rd_idx_o = rd_idx_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign hex_o    = hex_q;
endmodule
